// File: rtl/phase_detector.sv
// Edge-to-edge phase detector: signed clk-cycle error between ref_in and fb_in rising edges.
// Optional lock detection is built when PD_LOCK_DETECT_EN is defined.
module phase_detector #(
    parameter int CNT_W    = 12,
    parameter int LOCK_TOL = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             swiptAlive,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic [CNT_W-1:0] phase_err,
    output logic             err_valid,
    output logic             lead,
    output logic             lock
);

    localparam logic [CNT_W-1:0] MAX_ERR = {1'b0, {(CNT_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        FB_FIRST  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             ref_prev;
    logic             fb_prev;
    logic             ref_edge;
    logic             fb_edge;
    logic             clear;
    logic             emit;
    logic [CNT_W-1:0] emit_val;

    assign clear    = ~nrst | ~swiptAlive;
    assign ref_edge = ref_in & ~ref_prev;
    assign fb_edge  = fb_in & ~fb_prev;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        emit     = 1'b0;
        emit_val = '0;
        unique case (state)
            IDLE: begin
                if (ref_edge && fb_edge) begin
                    emit = 1'b1;
                end else if (ref_edge) begin
                    state_n = REF_FIRST;
                    cnt_n   = CNT_W'(1);
                end else if (fb_edge) begin
                    state_n = FB_FIRST;
                    cnt_n   = CNT_W'(1);
                end
            end
            REF_FIRST: begin
                if (fb_edge) begin
                    emit     = 1'b1;
                    emit_val = cnt;
                    // a simultaneous ref edge opens the next measurement
                    state_n  = ref_edge ? REF_FIRST : IDLE;
                    cnt_n    = CNT_W'(1);
                end else if (ref_edge) begin
                    emit     = 1'b1;
                    emit_val = MAX_ERR;
                    cnt_n    = CNT_W'(1);
                end else if (cnt == MAX_ERR) begin
                    emit     = 1'b1;
                    emit_val = MAX_ERR;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            FB_FIRST: begin
                if (ref_edge) begin
                    emit     = 1'b1;
                    emit_val = -cnt;
                    state_n  = fb_edge ? FB_FIRST : IDLE;
                    cnt_n    = CNT_W'(1);
                end else if (fb_edge) begin
                    emit     = 1'b1;
                    emit_val = -MAX_ERR;
                    cnt_n    = CNT_W'(1);
                end else if (cnt == MAX_ERR) begin
                    emit     = 1'b1;
                    emit_val = -MAX_ERR;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_prev  <= 1'b1;
            fb_prev   <= 1'b1;
            phase_err <= '0;
            err_valid <= 1'b0;
            lead      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ref_prev  <= ref_in;
            fb_prev   <= fb_in;
            err_valid <= emit;
            if (emit) begin
                phase_err <= emit_val;
                lead      <= ~emit_val[CNT_W-1] & (|emit_val);
            end
        end
    end

`ifdef PD_LOCK_DETECT_EN
    localparam int SW = $clog2(LOCK_CNT + 1);

    logic [SW-1:0]    streak;
    logic [CNT_W-1:0] mag;
    logic             in_tol;

    assign mag    = emit_val[CNT_W-1] ? -emit_val : emit_val;
    assign in_tol = (mag <= CNT_W'(LOCK_TOL));

    always_ff @(posedge clk) begin
        if (clear) begin
            streak <= '0;
            lock   <= 1'b0;
        end else if (emit && !in_tol) begin
            streak <= '0;
            lock   <= 1'b0;
        end else begin
            if (emit && streak != SW'(LOCK_CNT)) begin
                streak <= streak + SW'(1);
            end
            lock <= (streak == SW'(LOCK_CNT));
        end
    end
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_phase_detector.sv
// Directed bench for phase_detector: edge-pair errors, slip, timeout, abort, lock.
module tb_phase_detector;

`ifdef PD_LOCK_DETECT_EN
    localparam logic LD = 1'b1;
`else
    localparam logic LD = 1'b0;
`endif

    logic        clk;
    logic        nrst;
    logic        swiptAlive;
    logic        ref_in;
    logic        fb_in;
    logic [11:0] phase_err;
    logic        err_valid;
    logic        lead;
    logic        lock;

    int n_assert = 0;
    int n_fail   = 0;

    phase_detector #(
        .CNT_W(12),
        .LOCK_TOL(4),
        .LOCK_CNT(8)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .swiptAlive(swiptAlive),
        .ref_in(ref_in),
        .fb_in(fb_in),
        .phase_err(phase_err),
        .err_valid(err_valid),
        .lead(lead),
        .lock(lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // first input rises, the other rises d sample cycles later
    task automatic go(input logic rf, input int d);
        logic [11:0] ev;
        logic        el;
        ev = rf ? 12'(d) : 12'(-d);
        el = rf && (d > 0);
        @(posedge clk); #1;
        if (rf) ref_in = 1'b1; else fb_in = 1'b1;
        repeat (d) @(posedge clk);
        #1;
        if (rf) fb_in = 1'b1; else ref_in = 1'b1;
        @(negedge clk);
        check("pre_valid", 32'(err_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("valid", 32'(err_valid), 32'd1);
        check("err", 32'(phase_err), 32'(ev));
        check("lead", 32'(lead), 32'(el));
        @(negedge clk);
        check("single_strobe", 32'(err_valid), 32'd0);
        check("err_hold", 32'(phase_err), 32'(ev));
        @(posedge clk); #1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst       = 1'b0;
        swiptAlive = 1'b1;
        ref_in     = 1'b1;
        fb_in      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(err_valid), 32'd0);
        check("rst_err", 32'(phase_err), 32'd0);
        check("rst_lead", 32'(lead), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);

        // high levels at release are not edges
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_valid", 32'(err_valid), 32'd0);
            check("idle_err", 32'(phase_err), 32'd0);
        end
        check("idle_lead", 32'(lead), 32'd0);
        @(posedge clk); #1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (2) @(posedge clk);

        go(1'b1, 5);
        go(1'b0, 3);
        check("neg3_raw", 32'(phase_err), 32'h0000_0FFD);
        go(1'b1, 0);
        go(1'b1, 1);

        // cycle slip: two ref edges 50 cycles apart
        @(posedge clk); #1;
        ref_in = 1'b1;
        repeat (25) @(posedge clk);
        #1 ref_in = 1'b0;
        repeat (25) @(posedge clk);
        #1 ref_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("slip_valid", 32'(err_valid), 32'd1);
        check("slip_err", 32'(phase_err), 32'h7FF);
        check("slip_lead", 32'(lead), 32'd1);
        repeat (2) @(posedge clk);
        #1 fb_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_slip_valid", 32'(err_valid), 32'd1);
        check("after_slip_err", 32'(phase_err), 32'd3);
        @(posedge clk); #1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (2) @(posedge clk);

        // timeout: ref edge with no fb edge
        @(posedge clk); #1;
        ref_in = 1'b1;
        repeat (2047) @(posedge clk);
        @(negedge clk);
        check("to_early", 32'(err_valid), 32'd0);
        @(negedge clk);
        check("to_valid", 32'(err_valid), 32'd1);
        check("to_err", 32'(phase_err), 32'h7FF);
        check("to_lead", 32'(lead), 32'd1);
        @(posedge clk); #1;
        ref_in = 1'b0;
        repeat (2) @(posedge clk);
        go(1'b0, 4);

        // swiptAlive drop mid-measurement
        go(1'b1, 6);
        @(posedge clk); #1;
        ref_in = 1'b1;
        repeat (5) @(posedge clk);
        #1 swiptAlive = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", 32'(err_valid), 32'd0);
        check("abort_err", 32'(phase_err), 32'd0);
        check("abort_lead", 32'(lead), 32'd0);
        @(posedge clk); #1;
        swiptAlive = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("abort_quiet", 32'(err_valid), 32'd0);
        end
        @(posedge clk); #1;
        ref_in = 1'b0;
        repeat (2) @(posedge clk);

        // lock sequence
        for (int i = 0; i < 7; i++) go(1'b1, 2);
        check("lock_after7", 32'(lock), 32'd0);
        go(1'b1, 2);
        check("lock_after8", 32'(lock), 32'(LD));
        go(1'b1, 9);
        check("lock_after_big", 32'(lock), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_detector.md
# phase_detector

Digital phase detector directly downstream of the ADC comparator stage in the PLL loop. It measures the distance in clk cycles between rising edges of the 1-bit comparator reference (`ref_in`) and rising edges of the loop feedback (`fb_in`, from the DCO divider), and emits one signed phase-error word per edge pair. The loop filter consumes the error word, and the optional lock flag goes to the SWIPT control logic.

## Interface

Parameters:
- `CNT_W`, 12: phase-error width, signed two's complement. Saturation magnitude is `MAX_ERR = 2^(CNT_W-1)-1`.
- `LOCK_TOL`, 4: largest |error| counted as in-lock.
- `LOCK_CNT`, 8: consecutive in-tolerance measurements needed to assert lock.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `nrst`, in, 1: synchronous reset, active-low.
- `swiptAlive`, in, 1: when low, the block clears exactly as under reset.
- `ref_in`, in, 1: comparator reference level. Synchronous to clk.
- `fb_in`, in, 1: feedback level from the divider. Synchronous to clk.
- `phase_err`, out, CNT_W: signed error. Positive means the reference leads.
- `err_valid`, out, 1: one-cycle strobe qualifying `phase_err`.
- `lead`, out, 1: set when the last measurement had the reference first; clear when feedback was first or the error was 0.
- `lock`, out, 1: lock indicator. Present only with the lock-detect macro.

## Operation

Reset and clear:
- Reset is synchronous and active-low on `nrst`, clock `clk`.
- `nrst` low or `swiptAlive` low clears everything: state goes to IDLE; `phase_err`=0, `err_valid`=0, `lead`=0, `lock`=0; counter=0; lock streak=0; both previous-sample registers=1.

Edge detection:
- A rising edge is detected when the input is 1 in the current cycle and the previous-sample register holds 0.
- Because the previous-sample registers reset to 1, a level that is already high when reset is released is not an edge.

State machine (counter saturates at `MAX_ERR`):
- **IDLE**
  - ref edge only: go to REF_FIRST, cnt=1.
  - fb edge only: go to FB_FIRST, cnt=1.
  - Both edges in the same cycle: emit 0, stay in IDLE.
- **REF_FIRST**
  - fb edge: emit +cnt, go to IDLE. If a ref edge arrives in the same cycle, go to REF_FIRST with cnt=1 instead.
  - ref edge without fb edge (cycle slip): emit +`MAX_ERR`, stay, cnt=1.
  - cnt reaches `MAX_ERR` with no edge: emit +`MAX_ERR`, go to IDLE.
  - Otherwise: cnt+1.
- **FB_FIRST**: mirror of REF_FIRST with negated emitted values (−cnt, −`MAX_ERR`). Roles of ref and fb are swapped.

Emitting a value means: `phase_err` is loaded, `err_valid` pulses, and `lead` is updated.

Output holding:
- `phase_err` holds its value between strobes.
- `err_valid` is never high for two consecutive cycles unless two consecutive measurements close.

## Timing

- Edge-to-edge distance: a ref edge in sample cycle t and an fb edge in sample cycle t+d give `phase_err`=+d.
- Output latency: `err_valid` and `phase_err` are registered. They are visible on the clk edge after the cycle in which the closing edge is sampled.
- An edge sampled in the same cycle that reset is released is ignored.
- Reset or `swiptAlive` low in mid-measurement aborts the measurement with no strobe.

## Configuration

- `PD_LOCK_DETECT_EN` defined:
  - On each strobe with |`phase_err`| ≤ `LOCK_TOL`, the streak increments, saturating at `LOCK_CNT`.
  - `lock` asserts in the cycle after the streak reaches `LOCK_CNT`.
  - Any strobe with |error| > `LOCK_TOL`, including saturated values, clears the streak and `lock` in the same registered update.
- `PD_LOCK_DETECT_EN` undefined:
  - `lock` is tied to 0.
  - No streak logic is generated, and `LOCK_TOL`/`LOCK_CNT` are unused.

## Test plan

- Reset with `ref_in`=`fb_in`=1, then release: no strobe for 20 cycles, and all outputs stay 0.
- ref edge at cycle 10, fb edge at cycle 15: a single strobe with `phase_err`=+5 and `lead`=1, visible at cycle 16.
- fb edge at cycle 10, ref edge at cycle 13: strobe with `phase_err`=−3 (0xFFD) and `lead`=0.
- ref and fb edges in the same cycle: strobe with `phase_err`=0. Then two ref edges 50 cycles apart with no fb edge: strobe with +2047 (0x7FF).
- ref edge followed by no fb edge for 2047 cycles: strobe +0x7FF and return to IDLE. Also: `swiptAlive` dropped mid-count: no strobe, and outputs clear.
- With `PD_LOCK_DETECT_EN`: 8 pairs at error +2, giving `lock`=1 after the 8th strobe. Then one pair at +9, giving `lock`=0 on the next cycle.
